// File: rtl/riscv_halt_monitor_pkg.sv
// Shared types and constants for the halt monitor.
// No logic; consumed by import in the monitor files.
// No flow control; constants only.
package _riscv_defines;

    typedef enum logic [1:0] {
        HM_RUN     = 2'd0,
        HM_HALTED  = 2'd1,
        HM_TIMEOUT = 2'd2
    } halt_mon_state_e;

    // jal x0, 0 : the conventional "spin here forever" end-of-program idiom
    localparam logic [31:0] JAL_SELF_LOOP = 32'h0000006F;

    // Width of an index/counter able to address n values, never narrower than 1 bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_halt_monitor_match.sv
// Compares the issued instruction against every enabled halt pattern slot.
// Purely combinational, zero latency.
// No backpressure; invalid cycles never report a match.
module halt_pattern_match
    import _riscv_defines::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_PATTERNS = 2
) (
    input  logic [DATA_WIDTH-1:0]              instruction,
    input  logic                               instr_valid,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] halt_pattern,
    input  logic [NUM_PATTERNS-1:0]            pattern_en,
    output logic                               match,
    output logic [clog2_min1(NUM_PATTERNS)-1:0] match_idx
);

    localparam int IDX_W = clog2_min1(NUM_PATTERNS);

    // Scan upward and keep the first hit so the lowest slot wins on overlap
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (!match && instr_valid && pattern_en[i] &&
                (instruction == halt_pattern[i*DATA_WIDTH +: DATA_WIDTH])) begin
                match     = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_halt_monitor.sv
// End-of-program / watchdog monitor beside the core; optional result check via HALT_MON_RESULT_CHECK_EN.
// Latency: status registered one edge after the halting match or watchdog expiry.
// No backpressure: observes the instruction stream only, never stalls it.
module riscv_halt_monitor
    import _riscv_defines::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PATTERNS   = 2,
    parameter int CNT_WIDTH      = 32,
    parameter int HALT_REPEAT    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic [DATA_WIDTH-1:0]               instruction,
    input  logic                                instr_valid,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0]  halt_pattern,
    input  logic [NUM_PATTERNS-1:0]             pattern_en,
    output logic                                halted,
    output logic                                timed_out,
    output logic                                done_pulse,
    output logic [clog2_min1(NUM_PATTERNS)-1:0] match_idx,
    output logic [CNT_WIDTH-1:0]                cycle_count,
    output logic [CNT_WIDTH-1:0]                instr_count
`ifdef HALT_MON_RESULT_CHECK_EN
    ,
    input  logic [DATA_WIDTH-1:0]               result,
    input  logic [DATA_WIDTH-1:0]               expected,
    output logic                                pass,
    output logic                                fail
`endif
);

    localparam int IDX_W = clog2_min1(NUM_PATTERNS);
    localparam int REP_W = clog2_min1(HALT_REPEAT + 1);

    // rep_cnt value that, with one more match, completes the halting run
    localparam logic [REP_W-1:0]     REP_LAST = REP_W'(HALT_REPEAT - 1);
    localparam bit                   WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] WD_LAST  = CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    halt_mon_state_e        state_q, state_d;
    logic [REP_W-1:0]       rep_cnt_q;
    logic [CNT_WIDTH-1:0]   cycle_count_q;
    logic [CNT_WIDTH-1:0]   instr_count_q;
    logic [IDX_W-1:0]       match_idx_q;
    logic                   done_pulse_q;
    logic                   pm_match;
    logic [IDX_W-1:0]       pm_idx;
    logic                   in_run;
    logic                   halt_hit;
    logic                   wd_hit;

    halt_pattern_match #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_PATTERNS (NUM_PATTERNS)
    ) u_match (
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .halt_pattern (halt_pattern),
        .pattern_en   (pattern_en),
        .match        (pm_match),
        .match_idx    (pm_idx)
    );

    // Next-state: halt takes priority over watchdog expiry in the same cycle
    always_comb begin
        state_d  = state_q;
        in_run   = (state_q == HM_RUN);
        halt_hit = in_run && pm_match && (rep_cnt_q == REP_LAST);
        wd_hit   = WD_EN && in_run && (cycle_count_q == WD_LAST);
        case (state_q)
            HM_RUN: begin
                if (halt_hit) begin
                    state_d = HM_HALTED;
                end else if (wd_hit) begin
                    state_d = HM_TIMEOUT;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // State register; clear restarts exactly like reset
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= HM_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, repeat tracking and the halting slot; all frozen outside RUN
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            rep_cnt_q     <= '0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
            match_idx_q   <= '0;
            done_pulse_q  <= 1'b0;
        end else begin
            done_pulse_q <= in_run && (state_d != HM_RUN);
            if (in_run) begin
                if (cycle_count_q != '1) begin
                    cycle_count_q <= cycle_count_q + CNT_WIDTH'(1);
                end
                if (instr_valid) begin
                    if (instr_count_q != '1) begin
                        instr_count_q <= instr_count_q + CNT_WIDTH'(1);
                    end
                    // a valid non-match breaks the run; bubbles leave it untouched
                    rep_cnt_q <= pm_match ? (rep_cnt_q + REP_W'(1)) : '0;
                end
                if (halt_hit) begin
                    match_idx_q <= pm_idx;
                end
            end
        end
    end

`ifdef HALT_MON_RESULT_CHECK_EN
    logic pass_q;
    logic fail_q;

    // Verdict captured on the exit edge and held until restart
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (halt_hit) begin
            pass_q <= (result == expected);
            fail_q <= (result != expected);
        end else if (in_run && wd_hit) begin
            pass_q <= 1'b0;
            fail_q <= 1'b1;
        end
    end

    assign pass = pass_q;
    assign fail = fail_q;
`endif

    assign halted      = (state_q == HM_HALTED);
    assign timed_out   = (state_q == HM_TIMEOUT);
    assign done_pulse  = done_pulse_q;
    assign match_idx   = match_idx_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule
